// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a shared combinational AES-128 core.
// One request is in flight at a time: accept, wait CORE_LAT cycles, hold the response until it is consumed.
module aes_req_arbiter #(
    parameter int unsigned CORE_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_pt,
    input  logic [127:0] req0_key,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_pt,
    input  logic [127:0] req1_key,
    output logic [127:0] core_pt,
    output logic [127:0] core_key,
    input  logic [127:0] core_ct,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_ct,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    localparam logic [3:0] LAT4 = 4'(CORE_LAT);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         last_grant_q, last_grant_d;
    logic         rsp_id_q, rsp_id_d;
    logic [127:0] core_pt_q, core_pt_d;
    logic [127:0] core_key_q, core_key_d;
    logic [127:0] rsp_ct_q, rsp_ct_d;
    logic         grant0, grant1;

    // With both requesters valid, the one that did not win last time is granted.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        core_pt_d    = core_pt_q;
        core_key_d   = core_key_q;
        rsp_ct_d     = rsp_ct_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    core_pt_d    = req0_pt;
                    core_key_d   = req0_key;
                    rsp_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    cnt_d        = LAT4;
                    state_d      = CALC;
                end else if (req1_ready) begin
                    core_pt_d    = req1_pt;
                    core_key_d   = req1_key;
                    rsp_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    cnt_d        = LAT4;
                    state_d      = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_ct_d = core_ct;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            core_pt_q    <= '0;
            core_key_q   <= '0;
            rsp_ct_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            core_pt_q    <= core_pt_d;
            core_key_q   <= core_key_d;
            rsp_ct_q     <= rsp_ct_d;
        end
    end

    assign core_pt   = core_pt_q;
    assign core_key  = core_key_q;
    assign rsp_ct    = rsp_ct_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter CORE_LAT, default 2: cycles from a new core_pt/core_key being registered to core_ct being sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an encryption request.
REQ-005 req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 req0_pt  input  128  requester 0 plaintext.
REQ-007 req0_key  input  128  requester 0 key.
REQ-008 req1_valid, req1_ready, req1_pt, req1_key: same directions, widths and meanings for requester 1.
REQ-009 core_pt  output  128  registered plaintext driven to the shared combinational AES-128 core.
REQ-010 core_key  output  128  registered key driven to the shared core.
REQ-011 core_ct  input  128  ciphertext returned by the shared core.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester index owning the response.
REQ-015 rsp_ct  output  128  registered ciphertext.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, CALC and RESP shall be used; reset state IDLE.
REQ-018 reqN_ready shall be asserted only in IDLE, only for the granted requester, and shall be combinational from reqN_valid and last_grant.
REQ-019 Only one reqN_ready shall be high in any cycle.
REQ-020 Arbitration: a single valid requester is granted; with both valid, the requester not equal to last_grant is granted (round-robin).
REQ-021 On a transfer (reqN_valid & reqN_ready at a rising edge), core_pt/core_key shall load reqN_pt/reqN_key, rsp_id and last_grant shall load N, the latency counter shall load CORE_LAT, and the state shall go to CALC.
REQ-022 In CALC the counter shall decrement each cycle; in the cycle it equals 1, rsp_ct shall capture core_ct and the state shall go to RESP.
REQ-023 rsp_valid shall be high exactly in RESP; it shall rise CORE_LAT cycles after the transfer edge.
REQ-024 In RESP, rsp_valid, rsp_id and rsp_ct shall hold stable until rsp_valid & rsp_ready at an edge, after which the state shall go to IDLE.
REQ-025 rsp_ready high outside RESP shall be ignored.
REQ-026 core_pt/core_key shall change only on a transfer and hold the last accepted values otherwise.
REQ-027 Requester valid toggling or data changes in CALC/RESP shall have no effect on outputs.
REQ-028 Minimum spacing between transfers shall be CORE_LAT+2 cycles (accept, CORE_LAT x CALC, RESP, then IDLE).
REQ-029 A requester dropping valid before being granted shall lose no state; no request is queued internally.

Reset
REQ-030 While rst_n is low, regardless of clk: state=IDLE, counter=0, last_grant=1, core_pt=core_key=rsp_ct=0, rsp_id=0, rsp_valid=0, busy=0.
REQ-031 Reset asserted in CALC or RESP shall abandon the operation with no response produced; req0 shall win the first simultaneous request after reset.
REQ-032 reqN_ready shall be low while rst_n is low.

Verification
REQ-033 Core = aes_top model, CORE_LAT=2; req0 pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> req0_ready 1 cycle, rsp_valid 2 cycles after the transfer edge, rsp_id=0, rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 Both requesters valid continuously after reset with rsp_ready=1 -> grants alternate 0,1,0,1; each rsp_id matches the grant; transfers spaced 4 cycles.
REQ-035 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_ct/rsp_id stable for all 5 cycles, busy=1, both readys 0; release -> IDLE next edge.
REQ-036 rst_n pulsed low mid-CALC -> rsp_valid never rises for that request, all outputs 0, next simultaneous request is granted to req0.
REQ-037 Only req1 valid, back-to-back three requests -> all three granted to req1 despite last_grant=1, each with correct ciphertext.
